regfile: RTL and testbench
==========================

# regfile

General-purpose register file for the MIPS core: the receiving end of the writeback stage's `reg_d_*` write port. It provides two combinational read ports for the decode stage, with same-cycle write-to-read bypass. Register 0 is hardwired to zero. After reset, a clear sequencer zeroes every entry one address per cycle, so the storage can map to distributed RAM without a parallel reset, and asserts `busy` while it runs.

## Interface
- `ADDR_SIZE`, 5, register address width; depth N = 2^ADDR_SIZE
- `DATA_WIDTH`, 32, register width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `reg_d_we`  in  1  write enable from writeback
- `reg_d_addr`  in  ADDR_SIZE  write address
- `reg_d_data`  in  DATA_WIDTH  write data
- `reg_s_addr`  in  ADDR_SIZE  read port S address (rs)
- `reg_s_data`  out  DATA_WIDTH  read port S data
- `reg_t_addr`  in  ADDR_SIZE  read port T address (rt)
- `reg_t_data`  out  DATA_WIDTH  read port T data
- `busy`  out  1  clear sequencer active; the pipeline must stall

## Operation
- FSM states:
  - CLEAR: walk the array writing zeros.
  - RUN: normal operation.
- Reset behaviour:
  - `rst`=1 at an edge forces state=CLEAR and clear counter `clr_cnt`=0.
  - This applies in any state, including mid-clear; the walk restarts from 0.
- CLEAR:
  - Each edge with `rst`=0 does `mem[clr_cnt]<=0` and `clr_cnt<=clr_cnt+1`.
  - On the edge that writes address N-1, state<=RUN. No wrap: the counter is ADDR_SIZE bits and the transition fires before any overflow.
- `busy`:
  - `busy` = (state==CLEAR). It is a registered-state decode with no combinational path from inputs.
  - `busy` is 1 during reset and for N cycles after reset is released.
- Writes in CLEAR: `reg_d_we` is ignored and the write is dropped.
- Writes in RUN:
  - `reg_d_we`=1 with `reg_d_addr`!=0 does `mem[reg_d_addr]<=reg_d_data` at the edge.
  - Writes to address 0 are discarded.
- Reads, per port X in {S, T}, in priority order:
  1. state==CLEAR → 0.
  2. `reg_x_addr`==0 → 0.
  3. `reg_d_we` && `reg_d_addr`==`reg_x_addr` → `reg_d_data` (bypass).
  4. Otherwise `mem[reg_x_addr]`.
- Both ports may read the same address. Bypass applies to each port independently.
- Entry 0 of the array is never read, so its content is irrelevant.

## Timing
- Write latency: 1 edge. Through bypass, the value is visible on the read ports in the same cycle it is presented.
- Read latency: 0. Read data is combinational from addresses, write port inputs and state.
- Clear duration: exactly N rising edges with `rst`=0, i.e. 32 cycles at defaults. `busy` falls after the Nth edge.
- Output reset values: while `rst`=1 (from the first reset edge), `busy`=1 and `reg_s_data`=`reg_t_data`=0.
- Boundary cases:
  - Write to 0 together with a read of 0 → read returns 0 (no bypass).
  - Write and read of the same non-zero address in the same cycle → the read returns the new data.
  - `rst` asserted in the same cycle as a RUN write → the write is dropped, because reset has priority.
  - First RUN cycle: writes are accepted, and reads return 0 for every address not yet written.

## Structure
- A shared core package holds:
  - `REG_ADDR_SIZE`=5 and `WORD_WIDTH`=32 constants, shared with the writeback and decode stages.
  - Named constant `REG_ZERO`=0.
  - A state enum {CLEAR, RUN}.
- One sub-module, `regfile_read_port`: the combinational zero/bypass/array mux, instantiated twice (S, T).
- The FSM, clear counter and array live in `regfile`.

## Test plan
- Reset release: `rst` high 2 cycles, then low → `busy`=1 for exactly 32 cycles, then 0. All reads return 0 during that time.
- Basic write/read: in RUN, write 0xDEADBEEF to r5, then read S=5 and T=5 next cycle → both 0xDEADBEEF.
- Bypass: in the same cycle, write 0x12345678 to r7 with S=7, T=3 (r3=0xA5A5A5A5) → S=0x12345678, T=0xA5A5A5A5.
- Zero register: write 0xFFFFFFFF to r0 with S=0 → S=0 that cycle and the next.
- CLEAR interactions:
  - Write 0x55 to r9 while `busy`=1 → r9 reads 0 after clear completes.
  - Re-assert `rst` at clear cycle 10 → `busy` stays high for a fresh 32 cycles.
- Reset mid-run:
  - Fill r1..r31 with values equal to their index.
  - Pulse `rst` 1 cycle → after 32 busy cycles, all registers read 0.
  - A write asserted on the reset edge has no effect.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared core definitions for the register file and the stages around it.
//   REG_ADDR_SIZE : register address width (also used by writeback/decode)
//   WORD_WIDTH    : machine word width
//   REG_ZERO      : index of the hardwired-zero register
//   rf_state_t    : clear-sequencer state encoding
package regfile_pkg;

    localparam int unsigned REG_ADDR_SIZE = 5;
    localparam int unsigned WORD_WIDTH    = 32;
    localparam int unsigned REG_ZERO      = 0;

    typedef enum logic {
        CLEAR,
        RUN
    } rf_state_t;

endpackage

// File: rtl/regfile_if.sv
// Register file access bundle: writeback write port, two decode read ports
// and the busy stall indication.
//   master : pipeline side (drives write port and read addresses)
//   slave  : register file side (drives read data and busy)
interface regfile_if #(
    parameter int unsigned ADDR_SIZE  = 5,
    parameter int unsigned DATA_WIDTH = 32
);

    logic                  reg_d_we;
    logic [ADDR_SIZE-1:0]  reg_d_addr;
    logic [DATA_WIDTH-1:0] reg_d_data;
    logic [ADDR_SIZE-1:0]  reg_s_addr;
    logic [DATA_WIDTH-1:0] reg_s_data;
    logic [ADDR_SIZE-1:0]  reg_t_addr;
    logic [DATA_WIDTH-1:0] reg_t_data;
    logic                  busy;

    modport master (
        output reg_d_we,
        output reg_d_addr,
        output reg_d_data,
        output reg_s_addr,
        input  reg_s_data,
        output reg_t_addr,
        input  reg_t_data,
        input  busy
    );

    modport slave (
        input  reg_d_we,
        input  reg_d_addr,
        input  reg_d_data,
        input  reg_s_addr,
        output reg_s_data,
        input  reg_t_addr,
        output reg_t_data,
        output busy
    );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port of the register file.
//   clearing : clear sequencer active, forces zero
//   rd_addr  : read address
//   wr_en/wr_addr/wr_data : live write port, used for same-cycle bypass
//   mem_data : array contents at rd_addr
//   rd_data  : resolved read data
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_SIZE  = REG_ADDR_SIZE,
    parameter int unsigned DATA_WIDTH = WORD_WIDTH
) (
    input  logic                  clearing,
    input  logic [ADDR_SIZE-1:0]  rd_addr,
    input  logic                  wr_en,
    input  logic [ADDR_SIZE-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    always_comb begin
        rd_data = mem_data;
        if (clearing) begin
            rd_data = '0;
        end else if (rd_addr == ADDR_SIZE'(REG_ZERO)) begin
            // Checked before bypass so a write to r0 never leaks through.
            rd_data = '0;
        end else if (wr_en && (wr_addr == rd_addr)) begin
            rd_data = wr_data;
        end
    end

endmodule

// File: rtl/regfile.sv
// General-purpose register file: one write port from writeback, two
// combinational read ports (S, T) for decode with write-to-read bypass,
// r0 hardwired to zero. After reset a sequencer zeroes the array one entry
// per cycle so the storage needs no parallel reset.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   rf  : regfile_if slave (reg_d_*, reg_s_*, reg_t_*, busy)
module regfile
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_SIZE  = REG_ADDR_SIZE,
    parameter int unsigned DATA_WIDTH = WORD_WIDTH
) (
    input  logic     clk,
    input  logic     rst,
    regfile_if.slave rf
);

    localparam int unsigned          DEPTH     = 1 << ADDR_SIZE;
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = '1;

    rf_state_t             state, state_next;
    logic [ADDR_SIZE-1:0]  clr_cnt, clr_cnt_next;

    logic                  mem_we;
    logic [ADDR_SIZE-1:0]  mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  clearing;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    // Next state plus the single array write port, shared between the clear
    // walk and normal writeback. Reset suppresses any write on its edge.
    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        mem_we       = 1'b0;
        mem_waddr    = rf.reg_d_addr;
        mem_wdata    = rf.reg_d_data;
        unique case (state)
            CLEAR: begin
                mem_we       = ~rst;
                mem_waddr    = clr_cnt;
                mem_wdata    = '0;
                clr_cnt_next = clr_cnt + 1'b1;
                if (clr_cnt == LAST_ADDR) begin
                    state_next   = RUN;
                    clr_cnt_next = '0;
                end
            end
            RUN: begin
                mem_we = ~rst && rf.reg_d_we
                         && (rf.reg_d_addr != ADDR_SIZE'(REG_ZERO));
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign clearing = (state == CLEAR);
    assign rf.busy  = clearing;

    regfile_read_port #(
        .ADDR_SIZE (ADDR_SIZE),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_port_s (
        .clearing(clearing),
        .rd_addr (rf.reg_s_addr),
        .wr_en   (rf.reg_d_we),
        .wr_addr (rf.reg_d_addr),
        .wr_data (rf.reg_d_data),
        .mem_data(mem[rf.reg_s_addr]),
        .rd_data (rf.reg_s_data)
    );

    regfile_read_port #(
        .ADDR_SIZE (ADDR_SIZE),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_port_t (
        .clearing(clearing),
        .rd_addr (rf.reg_t_addr),
        .wr_en   (rf.reg_d_we),
        .wr_addr (rf.reg_d_addr),
        .wr_data (rf.reg_d_data),
        .mem_data(mem[rf.reg_t_addr]),
        .rd_data (rf.reg_t_data)
    );

endmodule

// File: tb/tb_regfile.sv
// Directed scoreboard bench for regfile. Stimulus sets inputs just after a
// rising edge and queues the expected read/busy values; the monitor samples
// on the falling edge and compares against the queue head.
module tb_regfile;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    regfile_if #(.ADDR_SIZE(5), .DATA_WIDTH(32)) rf_bus ();

    regfile #(.ADDR_SIZE(5), .DATA_WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .rf (rf_bus)
    );

    typedef struct {
        logic [31:0] s;
        logic [31:0] t;
        logic        busy;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    logic chk_req = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    // Monitor: one comparison per requested cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (chk_req) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: output present with no expectation");
            end else begin
                e = exp_q.pop_front();
                if (rf_bus.reg_s_data !== e.s || rf_bus.reg_t_data !== e.t
                    || rf_bus.busy !== e.busy) begin
                    errors++;
                    $display("FAIL %s: got s=%h t=%h busy=%b, expected s=%h t=%h busy=%b",
                             e.name, rf_bus.reg_s_data, rf_bus.reg_t_data, rf_bus.busy,
                             e.s, e.t, e.busy);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        chk_req = 1'b0;
    endtask

    task automatic drive(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                         input logic [4:0] saddr, input logic [4:0] taddr);
        rf_bus.reg_d_we   = we;
        rf_bus.reg_d_addr = waddr;
        rf_bus.reg_d_data = wdata;
        rf_bus.reg_s_addr = saddr;
        rf_bus.reg_t_addr = taddr;
    endtask

    task automatic expect_out(input logic [31:0] s, input logic [31:0] t, input logic busy,
                              input string name);
        exp_t e;
        e.s = s;
        e.t = t;
        e.busy = busy;
        e.name = name;
        exp_q.push_back(e);
        chk_req = 1'b1;
    endtask

    // Runs a full clear walk: the current cycle is clear cycle 0.
    task automatic clear_walk(input string name);
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
            expect_out(32'd0, 32'd0, 1'b1, name);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        rst = 1'b1;
        tick();
        // After the first reset edge
        drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd9);
        expect_out(32'd0, 32'd0, 1'b1, "reset_state");
        tick();
        rst = 1'b0;

        // Clear walk with a write attempted on r9 mid-clear
        for (int i = 0; i < 32; i++) begin
            if (i == 3) drive(1'b1, 5'd9, 32'h55, 5'(i), 5'd9);
            else        drive(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
            expect_out(32'd0, 32'd0, 1'b1, "clear_busy");
            tick();
        end

        // First RUN cycle
        drive(1'b0, 5'd0, 32'd0, 5'd9, 5'd1);
        expect_out(32'd0, 32'd0, 1'b0, "first_run_r9_dropped");
        tick();

        // Basic write / read (bypass same cycle, array next cycle)
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
        expect_out(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, "write_r5_bypass");
        tick();
        drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
        expect_out(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, "read_r5");
        tick();

        drive(1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd0);
        expect_out(32'hA5A5A5A5, 32'd0, 1'b0, "write_r3");
        tick();

        // Bypass on S only, T reads array
        drive(1'b1, 5'd7, 32'h12345678, 5'd7, 5'd3);
        expect_out(32'h12345678, 32'hA5A5A5A5, 1'b0, "bypass_r7");
        tick();

        // Zero register
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd7);
        expect_out(32'd0, 32'h12345678, 1'b0, "write_r0_same");
        tick();
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd5);
        expect_out(32'd0, 32'hDEADBEEF, 1'b0, "write_r0_next");
        tick();

        // Fill r1..r31 with their index
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 5'(i), 32'(i), 5'(i), 5'(i - 1));
            expect_out(32'(i), 32'(i - 1), 1'b0, "fill_bypass");
            tick();
        end
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'd0, 5'(i), 5'(32 - i));
            expect_out(32'(i), 32'(32 - i), 1'b0, "fill_readback");
            tick();
        end

        // Reset pulse with a concurrent write; state is still RUN pre-edge
        rst = 1'b1;
        drive(1'b1, 5'd5, 32'hCAFEF00D, 5'd5, 5'd6);
        expect_out(32'hCAFEF00D, 32'd6, 1'b0, "reset_edge_pre");
        tick();
        rst = 1'b0;
        clear_walk("midrun_clear_busy");
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
            expect_out(32'd0, 32'd0, 1'b0, "midrun_all_zero");
            tick();
        end

        // Reset re-asserted at clear cycle 10 restarts the walk
        drive(1'b1, 5'd4, 32'h44, 5'd4, 5'd0);
        expect_out(32'h44, 32'd0, 1'b0, "write_r4");
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 5'd0, 32'd0, 5'd4, 5'd1);
            expect_out(32'd0, 32'd0, 1'b1, "partial_clear");
            tick();
        end
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 5'd4, 5'd1);
        expect_out(32'd0, 32'd0, 1'b1, "reset_mid_clear");
        tick();
        rst = 1'b0;
        clear_walk("fresh_clear_busy");
        drive(1'b0, 5'd0, 32'd0, 5'd4, 5'd31);
        expect_out(32'd0, 32'd0, 1'b0, "after_fresh_clear");
        tick();

        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
